// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg -- shared types and helpers for the LED pattern generator.
//   led_mode_t : pattern engine selector (up, down, ping-pong scan, Gray)
//   PWM_W      : width of the optional brightness PWM counter
//   presc_w()  : prescaler counter width for a given divide ratio
// ---------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      MODE_UP   = 2'd0,
      MODE_DOWN = 2'd1,
      MODE_SCAN = 2'd2,
      MODE_GRAY = 2'd3
   } led_mode_t;

   localparam int PWM_W = 4;

   // At least one bit, even for the smallest legal divider (DIV = 2).
   function automatic int presc_w(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen -- prescaler that strobes 'tick' once every DIV enabled cycles.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   en    : count enable; the prescaler holds (is not cleared) while low
//   tick  : high while en=1 and the prescaler sits at DIV-1
// ---------------------------------------------------------------------------
module tick_gen
   import led_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = presc_w(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen -- prescaled LED pattern engine driving an LED bank.
//   clk       : board clock
//   rst_n     : asynchronous active-low reset
//   en        : 1 = free-run on prescaler ticks, 0 = advance only on step
//   step      : single-cycle manual advance, honoured only while en=0
//   mode      : 0 up, 1 down, 2 ping-pong scan, 3 Gray up
//   bright    : (LED_PWM_EN only) PWM duty in 1/16ths
//   tick_o    : one-cycle strobe, coincident with a new pattern
//   pattern_o : logical pattern (1 = lit)
//   led       : physical pins after polarity (and PWM, if enabled)
// Optional feature macro: LED_PWM_EN
// ---------------------------------------------------------------------------
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int CLK_HZ     = 27000000,
   parameter int TICK_HZ    = 2,
   parameter int LED_W      = 6,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             step,
   input  logic [1:0]       mode,
`ifdef LED_PWM_EN
   input  logic [PWM_W-1:0] bright,
`endif
   output logic             tick_o,
   output logic [LED_W-1:0] pattern_o,
   output logic [LED_W-1:0] led
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam logic [LED_W-1:0] ONE = LED_W'(1);

   logic       tick;
   logic       adv;
   led_mode_t  mode_in;
   led_mode_t  mode_q, mode_d;
   logic [LED_W-1:0] pat_q, pat_d;
   logic [LED_W-1:0] bin_q, bin_d;
   logic       dir_q, dir_d;      // scan direction of the next move: 0 left, 1 right
   logic       tick_q;
   logic [LED_W-1:0] lit;

   tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   assign adv     = tick || (!en && step);
   assign mode_in = led_mode_t'(mode);

   always_comb begin
      mode_d = mode_q;
      pat_d  = pat_q;
      bin_d  = bin_q;
      dir_d  = dir_q;
      if (adv) begin
         if (mode_in != mode_q) begin
            // A mode change shows the new mode's start value instead of advancing.
            mode_d = mode_in;
            case (mode_in)
               MODE_UP:   begin bin_d = '0; pat_d = '0; end
               MODE_DOWN: begin bin_d = '1; pat_d = '1; end
               MODE_SCAN: begin pat_d = ONE; dir_d = 1'b0; end
               default:   begin bin_d = '0; pat_d = '0; end
            endcase
         end else begin
            case (mode_q)
               MODE_UP: begin
                  bin_d = bin_q + 1'b1;
                  pat_d = bin_d;
               end
               MODE_DOWN: begin
                  bin_d = bin_q - 1'b1;
                  pat_d = bin_d;
               end
               MODE_SCAN: begin
                  // Flip direction as the end bit is reached so it shows only once.
                  if (LED_W > 1) begin
                     if (!dir_q) begin
                        pat_d = pat_q << 1;
                        if (pat_d[LED_W-1]) dir_d = 1'b1;
                     end else begin
                        pat_d = pat_q >> 1;
                        if (pat_d[0]) dir_d = 1'b0;
                     end
                  end
               end
               default: begin
                  bin_d = bin_q + 1'b1;
                  pat_d = bin_d ^ (bin_d >> 1);
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_UP;
         pat_q  <= '0;
         bin_q  <= '0;
         dir_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         pat_q  <= pat_d;
         bin_q  <= bin_d;
         dir_q  <= dir_d;
         tick_q <= adv;
      end
   end

   assign tick_o    = tick_q;
   assign pattern_o = pat_q;

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) p_q <= '0;
      else        p_q <= p_q + 1'b1;
   end

   assign lit = pat_q & {LED_W{p_q < bright}};
`else
   assign lit = pat_q;
`endif

   assign led = ACTIVE_LOW ? ~lit : lit;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern generator and successor to the fixed single-rate LED binary counter. A prescaler derives a tick from the board clock. On each tick a selectable pattern engine advances: binary up, binary down, ping-pong scan or Gray count. The block drives the on-board LED bank directly with configurable polarity, and exports a tick strobe for other playground and debug logic.

Parameters:
CLK_HZ, 27000000, input clock frequency in Hz
TICK_HZ, 2, pattern advance rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, DIV >= 2
LED_W, 6, number of LEDs / pattern width, 1..32
ACTIVE_LOW, 1, 1 = LED lit when pin low (led = ~pattern); 0 = led = pattern

Ports:
clk  in  1  board clock; the block's only clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = free-run on prescaler ticks; 0 = hold, advance only on step
step  in  1  single-cycle manual advance request; honoured only while en=0
mode  in  2  0 binary up, 1 binary down, 2 ping-pong scan, 3 Gray up
tick_o  out  1  one-cycle strobe, high in the first cycle the new pattern is visible
pattern_o  out  LED_W  logical pattern (1 = lit)
led  out  LED_W  physical LED pins after polarity

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Assertion clears all state immediately, independent of clk.
- Reset values: prescaler 0, pattern_o 0, internal binary count 0, scan direction left, latched mode 0, tick_o 0. led is all-ones when ACTIVE_LOW=1, otherwise all-zeros.
- Prescaler: counts 0..DIV-1 and wraps. It runs only while en=1 and holds its value while en=0 (it is not cleared).
- Advance event: asserted when (en=1 and prescaler==DIV-1) or (en=0 and step=1). step is ignored while en=1.
- Latency: pattern_o and led update on the clock edge that samples the advance event. tick_o is registered and is high for exactly one cycle, coincident with the new pattern.
- mode is sampled only at an advance event. If it differs from the latched mode, the pattern loads the start value of the new mode instead of advancing, and the latched mode updates.
- Start values:
  - up: 0
  - down: all-ones
  - scan: one-hot bit 0, direction left
  - Gray: count 0
- Binary up/down: modulo 2^LED_W. Up wraps all-ones to 0; down wraps 0 to all-ones.
- Scan: one-hot shifts left until the MSB is set, then reverses. The end bit is shown for one tick only, so it is never repeated. With LED_W=1 the pattern stays at 1.
- Gray: internal count b increments modulo 2^LED_W; pattern_o = b ^ (b>>1), registered.
- Reset mid-operation: everything returns to reset values at once. The first tick after release occurs DIV cycles after release with en=1.

Optional Feature:
LED_PWM_EN
- Defined: adds input port bright[3:0] and a free-running 4-bit PWM counter p. LED bit i is lit when pattern_o[i]=1 and p < bright. bright=0 gives all dark; bright=15 gives 15/16 duty. pattern_o and tick_o are unaffected. p resets to 0.
- Not defined: the bright port is absent and led is the polarity-adjusted pattern_o at full duty.

Decomposition:
- Package led_pkg holds:
  - the mode enum typedef led_mode_t (MODE_UP=0, MODE_DOWN=1, MODE_SCAN=2, MODE_GRAY=3)
  - the PWM width constant PWM_W=4
  - a clog2-based helper for prescaler width
- One sub-module, tick_gen: parameter DIV; ports clk, rst_n, en; output tick. It contains the prescaler and the wrap compare.

Test Plan:
All scenarios use CLK_HZ=8, TICK_HZ=2 (DIV=4), LED_W=6, ACTIVE_LOW=1.
1. Release reset, en=1, mode=0 -> tick_o every 4th cycle; pattern 0,1,2,…,63,0 (wrap); led = ~pattern, 111111 out of reset.
2. mode=2 from reset -> first tick loads 000001, then 000010, …, 100000, 010000, …, 000001; no end bit is repeated.
3. mode=0, pattern=5, switch to mode=1 -> next tick gives 111111, then 111110; mode=1 continued from 0 -> 111111 (wrap).
4. en=0 with three isolated step pulses -> pattern advances exactly 3 and tick_o pulses 3 times. en=1 with step held high -> only prescaler ticks advance the pattern.
5. rst_n low for one cycle mid-count, asynchronous to clk -> pattern_o 0 and led 111111 immediately. First tick comes 4 cycles after release.
6. mode=3 -> Gray sequence 0,1,3,2,6,7,5,4; with LED_PWM_EN and bright=8 -> each lit LED pin is low for 8 of every 16 cycles.
